// File: rtl/mult_control_param_if.sv
// Control/status bundle between the shift-add multiplier sequencer and its
// datapath/front panel. The sequencer takes the slave side; whatever drives
// Run/ClearA_LoadB and owns the A:B registers takes the master side.
interface mult_control_param_if #(
   parameter int WIDTH = 8
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   // requests and datapath feedback
   logic             Run;
   logic             ClearA_LoadB;
   logic             M;
   logic             Signed_Mode;

   // datapath enables and status
   logic             Reset_c;
   logic             Clr_Ld;
   logic             Clr_A;
   logic             Add;
   logic             Fn;
   logic             Shift_En;
   logic             Busy;
   logic             Done;
   logic [CNT_W-1:0] Step_Cnt;

   modport master (
      output Run, ClearA_LoadB, M, Signed_Mode,
      input  Reset_c, Clr_Ld, Clr_A, Add, Fn, Shift_En, Busy, Done, Step_Cnt
   );

   modport slave (
      input  Run, ClearA_LoadB, M, Signed_Mode,
      output Reset_c, Clr_Ld, Clr_A, Add, Fn, Shift_En, Busy, Done, Step_Cnt
   );
endinterface

// File: rtl/mult_control_param.sv
// Sequencer for the shift-add multiplier: one ADD/SHIFT state pair looped
// WIDTH times by an iteration counter. Only produces datapath enables and
// status; the operands never pass through here.
module mult_control_param #(
   parameter int WIDTH = 8
) (
   input logic                  Clk,
   input logic                  Reset,
   mult_control_param_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_RST   = 3'd0,
      S_IDLE  = 3'd1,
      S_LOAD  = 3'd2,
      S_START = 3'd3,
      S_ADD   = 3'd4,
      S_SHIFT = 3'd5,
      S_DONE  = 3'd6,
      S_HOLD  = 3'd7
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             mode_q;
   logic             last_step;

   assign last_step = (cnt == LAST);

   // State, iteration counter and latched signed mode
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= S_RST;
         cnt    <= '0;
         mode_q <= 1'b0;
      end else begin
         case (state)
            S_RST:   state <= S_IDLE;
            S_IDLE: begin
               // Run wins over ClearA_LoadB. The counter is cleared on the
               // way into START so Step_Cnt already reads 0 during START.
               if (bus.Run) begin
                  state <= S_START;
                  cnt   <= '0;
               end else if (bus.ClearA_LoadB) begin
                  state <= S_LOAD;
               end
            end
            S_LOAD:  state <= S_IDLE;
            S_START: begin
               cnt    <= '0;
               mode_q <= bus.Signed_Mode;
               state  <= S_ADD;
            end
            S_ADD:   state <= S_SHIFT;
            S_SHIFT: begin
               cnt   <= cnt + 1'b1;
               state <= last_step ? S_DONE : S_ADD;
            end
            S_DONE:  state <= S_HOLD;
            // Wait for Run release so a held Run cannot start a second run
            S_HOLD:  if (!bus.Run) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Output decode from state, counter, latched mode and the multiplier LSB
   always_comb begin
      bus.Reset_c  = 1'b0;
      bus.Clr_Ld   = 1'b0;
      bus.Clr_A    = 1'b0;
      bus.Add      = 1'b0;
      bus.Fn       = 1'b0;
      bus.Shift_En = 1'b0;
      bus.Busy     = 1'b0;
      bus.Done     = 1'b0;
      case (state)
         S_RST:   bus.Reset_c = 1'b1;
         S_IDLE:  ;
         S_LOAD:  bus.Clr_Ld = 1'b1;
         S_START: begin
            bus.Clr_A = 1'b1;
            bus.Busy  = 1'b1;
         end
         S_ADD: begin
            // Two's-complement: the sign bit of the multiplier has negative
            // weight, so the final partial product is subtracted.
            bus.Busy = 1'b1;
            bus.Add  = bus.M;
            bus.Fn   = mode_q & bus.M & last_step;
         end
         S_SHIFT: begin
            bus.Busy     = 1'b1;
            bus.Shift_En = 1'b1;
         end
         S_DONE:  bus.Done = 1'b1;
         S_HOLD:  ;
         default: bus.Reset_c = 1'b1;
      endcase
   end

   assign bus.Step_Cnt = cnt;
endmodule

// File: tb/tb_mult_control_param.sv
// Bench for the multiplier sequencer: a WIDTH=8 and a WIDTH=4 instance share
// stimulus; each cycle is checked against a timeline model derived from the
// cycle-numbered schedule of a run (START, ADD/SHIFT pairs, DONE, HOLD).
module tb_mult_control_param;
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   logic run = 1'b0, clr = 1'b0, m = 1'b0, sm = 1'b0;

   int tests = 0;
   int fails = 0;

   mult_control_param_if #(.WIDTH(8)) if8 ();
   mult_control_param_if #(.WIDTH(4)) if4 ();

   assign if8.Run = run;  assign if8.ClearA_LoadB = clr;
   assign if8.M   = m;    assign if8.Signed_Mode  = sm;
   assign if4.Run = run;  assign if4.ClearA_LoadB = clr;
   assign if4.M   = m;    assign if4.Signed_Mode  = sm;

   mult_control_param #(.WIDTH(8)) dut8 (.Clk(Clk), .Reset(Reset), .bus(if8));
   mult_control_param #(.WIDTH(4)) dut4 (.Clk(Clk), .Reset(Reset), .bus(if4));

   always #5 Clk = ~Clk;

   // {Reset_c, Clr_Ld, Clr_A, Add, Fn, Shift_En, Busy, Done}
   logic [7:0] o8, o4, c8, c4;
   assign o8 = {if8.Reset_c, if8.Clr_Ld, if8.Clr_A, if8.Add, if8.Fn, if8.Shift_En, if8.Busy, if8.Done};
   assign o4 = {if4.Reset_c, if4.Clr_Ld, if4.Clr_A, if4.Add, if4.Fn, if4.Shift_En, if4.Busy, if4.Done};
   assign c8 = 8'(if8.Step_Cnt);
   assign c4 = 8'(if4.Step_Cnt);

   // Expected outputs in cycle n after Run is sampled at edge 0
   function automatic logic [7:0] exp_out(int w, int n, bit smode, bit mv);
      if (n == 1)                          return 8'b0010_0010;
      if (n >= 2 && n <= 2*w && n%2 == 0)  return {3'b000, mv, smode & mv & (n == 2*w), 3'b010};
      if (n >= 3 && n <= 2*w+1)            return 8'b0000_0110;
      if (n == 2*w+2)                      return 8'b0000_0001;
      return 8'b0;
   endfunction

   function automatic logic [7:0] exp_cnt(int w, int n);
      if (n <= 1)      return 8'd0;
      if (n <= 2*w+1)  return 8'((n-2)/2);
      return 8'(w);
   endfunction

   task automatic tick();
      @(posedge Clk); #1;
   endtask

   task automatic settle();
      run = 1'b0; clr = 1'b0;
      repeat (24) tick();
   endtask

   task automatic test_reset();
      Reset = 1'b1; run = 1'b0; clr = 1'b0;
      tick(); #1;
      tests++; if (o8 !== 8'b1000_0000) begin fails++; $display("FAIL reset_out8 got=%b exp=%b", o8, 8'b1000_0000); end
      tests++; if (o4 !== 8'b1000_0000) begin fails++; $display("FAIL reset_out4 got=%b exp=%b", o4, 8'b1000_0000); end
      tests++; if (c8 !== 8'd0 || c4 !== 8'd0) begin fails++; $display("FAIL reset_cnt got=%0d/%0d exp=0", c8, c4); end
      Reset = 1'b0;
      tick(); #1;
      tests++; if (o8 !== 8'b0 || o4 !== 8'b0) begin fails++; $display("FAIL reset_idle got=%b/%b exp=0", o8, o4); end
   endtask

   // One multiply; mmode 0: M=1, 1: random, 2: 1,0,1,1 pattern per ADD cycle
   task automatic test_mult(int w, bit smode, int mmode, bit toggle);
      logic [7:0] pat;
      logic [7:0] ob, oc, e;
      bit mv;
      pat = 8'b1101_1101;  // LSB-first: 1,0,1,1,...
      run = 1'b1; sm = smode;
      for (int n = 1; n <= 2*w+3; n++) begin
         tick();
         run = 1'b0;
         if (toggle && n == 5) sm = ~sm;
         case (mmode)
            0:       mv = 1'b1;
            1:       mv = 1'($urandom_range(0, 1));
            default: mv = pat[((n/2)-1) % 8];
         endcase
         m = mv;
         #1;
         ob = (w == 8) ? o8 : o4;
         oc = (w == 8) ? c8 : c4;
         e  = exp_out(w, n, smode, mv);
         tests++; if (ob !== e) begin fails++; $display("FAIL mult_w%0d_s%0d_c%0d outs got=%b exp=%b", w, smode, n, ob, e); end
         tests++; if (oc !== exp_cnt(w, n)) begin fails++; $display("FAIL mult_w%0d_c%0d cnt got=%0d exp=%0d", w, n, oc, exp_cnt(w, n)); end
      end
      m = 1'b0; sm = 1'b0;
      settle();
   endtask

   task automatic test_load();
      clr = 1'b1;
      tick(); clr = 1'b0; #1;
      tests++; if (o8 !== 8'b0100_0000) begin fails++; $display("FAIL load_strobe got=%b exp=%b", o8, 8'b0100_0000); end
      tick(); #1;
      tests++; if (o8 !== 8'b0) begin fails++; $display("FAIL load_back_idle got=%b exp=0", o8); end
      run = 1'b1; clr = 1'b1;
      tick(); run = 1'b0; clr = 1'b0; #1;
      tests++; if (o8 !== 8'b0010_0010) begin fails++; $display("FAIL run_over_load got=%b exp=%b", o8, 8'b0010_0010); end
      settle();
   endtask

   task automatic test_run_held();
      int dones;
      logic [7:0] e;
      dones = 0;
      run = 1'b1; m = 1'b1; sm = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         tick(); #1;
         if (o8[0]) dones++;
         e = exp_out(8, n, 1'b0, 1'b1);
         tests++; if (o8 !== e) begin fails++; $display("FAIL held_c%0d got=%b exp=%b", n, o8, e); end
      end
      tests++; if (dones != 1) begin fails++; $display("FAIL held_done_count got=%0d exp=1", dones); end
      run = 1'b0;
      tick(); #1;
      tests++; if (o8 !== 8'b0 || c8 !== 8'd8) begin fails++; $display("FAIL held_idle got=%b cnt=%0d exp=0 cnt=8", o8, c8); end
      run = 1'b1;
      tick(); run = 1'b0; #1;
      tests++; if (o8 !== 8'b0010_0010 || c8 !== 8'd0) begin fails++; $display("FAIL held_restart got=%b cnt=%0d exp=%b cnt=0", o8, c8, 8'b0010_0010); end
      m = 1'b0;
      settle();
   endtask

   task automatic test_reset_mid();
      logic [7:0] e;
      run = 1'b1; m = 1'b1; sm = 1'b1;
      for (int n = 1; n <= 7; n++) begin
         tick(); run = 1'b0; #1;
         e = exp_out(8, n, 1'b1, 1'b1);
         tests++; if (o8 !== e) begin fails++; $display("FAIL rmid_c%0d got=%b exp=%b", n, o8, e); end
      end
      Reset = 1'b1;
      tick(); Reset = 1'b0; #1;
      tests++; if (o8 !== 8'b1000_0000 || o4 !== 8'b1000_0000) begin fails++; $display("FAIL rmid_rst got=%b/%b exp=%b", o8, o4, 8'b1000_0000); end
      tests++; if (c8 !== 8'd0 || c4 !== 8'd0) begin fails++; $display("FAIL rmid_cnt got=%0d/%0d exp=0", c8, c4); end
      tick(); #1;
      tests++; if (o8 !== 8'b0 || o4 !== 8'b0) begin fails++; $display("FAIL rmid_idle got=%b/%b exp=0", o8, o4); end
      m = 1'b0; sm = 1'b0;
      settle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++)
         test_mult(($urandom_range(0, 1) != 0) ? 8 : 4, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)));
   endtask

   initial begin
      test_reset();
      test_mult(8, 1'b1, 0, 1'b0);
      test_mult(8, 1'b0, 0, 1'b1);
      test_mult(4, 1'b1, 2, 1'b0);
      test_load();
      test_run_held();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
